lsu_stage: RTL and testbench

- Memory stage directly downstream of the ALU in the MIPS datapath.
- Consumes the ALU result as either a pass-through value or a load/store byte address (the ALU's LWSW op).
- Runs a single-outstanding req/ack transaction to data memory and drives the writeback port.
- Back-pressures the execute stage with stall while a transaction is in flight.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_timer.sv | 51 +++++
 rtl/lsu_stage.sv | 198 +++++++++++++++++++
 tb/tb_lsu_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg - shared types and constants for the load/store memory stage.
//
// Contents:
//   lsu_state_e       two-state FSM encoding (IDLE, WAIT)
//   S_IDLE / S_WAIT   the same encodings as plain localparam constants
//   WORD_W, REG_W     data word and register-index widths
//   ALIGN_MASK        low address bits that must be zero for a word access
//   tmr_width()       width of the optional timeout counter (4-bit minimum)
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Counter must hold values up to TIMEOUT; never narrower than 4 bits.
  function automatic int unsigned tmr_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/lsu_timer.sv
// -----------------------------------------------------------------------------
// lsu_timer - wait-cycle counter for the memory stage timeout.
//
// Only instantiated when LSU_TIMEOUT_EN is defined.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset, clears the count
//   i_clear    load the count with zero (held while the stage is idle)
//   i_inc      one more WAIT cycle passed without an ack
//   o_expired  this increment brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module lsu_timer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int unsigned CNT_W = tmr_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  // r_cnt counts completed ack-less WAIT cycles, so the increment taken in the
  // TIMEOUT-th such cycle is the one that reaches TIMEOUT.
  assign o_expired = i_inc && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clear) begin
      w_cnt_d = '0;
    end else if (i_inc) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// -----------------------------------------------------------------------------
// lsu_stage - MIPS memory stage downstream of the ALU.
//
// Pass-through ops write the ALU result back one cycle later. Loads/stores use
// the ALU result as a byte address and run a single-outstanding req/ack
// transaction to data memory; the execute stage is stalled while it is open.
//
// Optional build macro: LSU_TIMEOUT_EN - abort a transaction after TIMEOUT
// ack-less WAIT cycles and pulse bus_err. Without it, WAIT waits forever and
// bus_err is tied low.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   ex_valid/is_load/is_store     op presented by execute
//   ex_result, ex_wdata, ex_rd    ALU result / address, store data, dest reg
//   stall                         execute must hold its inputs
//   mem_req/we/addr/wdata         memory request (held stable while waiting)
//   mem_ack, mem_rdata            memory completion and load data
//   wb_valid, wb_rd, wb_data      writeback pulse
//   misalign, bus_err             one-cycle error pulses
// -----------------------------------------------------------------------------
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign,
  output logic              bus_err
);

  if (ADDR_W < 2 || ADDR_W > WORD_W || TIMEOUT < 1) begin : g_bad_param
    $error("lsu_stage: ADDR_W must be 2..32 and TIMEOUT at least 1");
  end

  logic [0:0]        r_state;
  logic [0:0]        w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_d;
  logic              r_we;
  logic              w_we_d;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] w_wdata_d;
  logic [REG_W-1:0]  r_rd;
  logic [REG_W-1:0]  w_rd_d;
  logic              r_wb_valid;
  logic              w_wb_valid_d;
  logic [REG_W-1:0]  r_wb_rd;
  logic [REG_W-1:0]  w_wb_rd_d;
  logic [WORD_W-1:0] r_wb_data;
  logic [WORD_W-1:0] w_wb_data_d;
  logic              r_misalign;
  logic              w_misalign_d;
  logic              r_bus_err;
  logic              w_bus_err_d;

  logic w_waiting;
  logic w_accept;
  logic w_is_mem;
  logic w_is_store;
  logic w_unaligned;
  logic w_timeout;

  assign w_waiting   = (r_state == S_WAIT);
  assign w_accept    = ex_valid && !w_waiting;
  assign w_is_mem    = ex_is_load || ex_is_store;
  // Load wins when both flags are set.
  assign w_is_store  = ex_is_store && !ex_is_load;
  assign w_unaligned = (ex_result[1:0] & ALIGN_MASK) != 2'b00;

`ifdef LSU_TIMEOUT_EN
  logic w_tmr_clear;
  logic w_tmr_inc;

  // Held clear while idle so the count starts at zero on entry to WAIT.
  assign w_tmr_clear = !w_waiting;
  assign w_tmr_inc   = w_waiting && !mem_ack;

  lsu_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .i_inc    (w_tmr_inc),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_we_d       = r_we;
    w_wdata_d    = r_wdata;
    w_rd_d       = r_rd;
    w_wb_valid_d = 1'b0;
    w_wb_rd_d    = r_wb_rd;
    w_wb_data_d  = r_wb_data;
    w_misalign_d = 1'b0;
    w_bus_err_d  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem) begin
            w_wb_valid_d = 1'b1;
            w_wb_rd_d    = ex_rd;
            w_wb_data_d  = ex_result;
          end else if (w_unaligned) begin
            w_misalign_d = 1'b1;
          end else begin
            w_state_d = S_WAIT;
            w_addr_d  = ex_result[ADDR_W-1:0];
            w_we_d    = w_is_store;
            w_wdata_d = ex_wdata;
            w_rd_d    = ex_rd;
          end
        end
      end
      S_WAIT: begin
        // An ack in the timeout cycle still completes the access.
        if (mem_ack) begin
          w_state_d = S_IDLE;
          if (!r_we) begin
            w_wb_valid_d = 1'b1;
            w_wb_rd_d    = r_rd;
            w_wb_data_d  = mem_rdata;
          end
        end else if (w_timeout) begin
          w_state_d   = S_IDLE;
          w_bus_err_d = 1'b1;
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_we       <= w_we_d;
      r_wdata    <= w_wdata_d;
      r_rd       <= w_rd_d;
      r_wb_valid <= w_wb_valid_d;
      r_wb_rd    <= w_wb_rd_d;
      r_wb_data  <= w_wb_data_d;
      r_misalign <= w_misalign_d;
      r_bus_err  <= w_bus_err_d;
    end
  end

  // mem_req follows state directly so an async reset drops it at once.
  assign stall     = w_waiting;
  assign mem_req   = w_waiting;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [31:0] ex_result;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_stage #(
    .ADDR_W (32),
    .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_is_store(ex_is_store),
    .ex_result  (ex_result),
    .ex_wdata   (ex_wdata),
    .ex_rd      (ex_rd),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_result   = 32'h0;
    ex_wdata    = 32'h0;
    ex_rd       = 5'd0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [31:0] res,
                       input logic [31:0] wd, input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_result   = res;
    ex_wdata    = wd;
    ex_rd       = rd;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [103:0] outs;
    idle_inputs();
    rst = 1'b1;
    #2;
    outs = {stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rd, misalign, bus_err};
    n_checks++;
    if (outs !== 104'h0) begin
      $display("FAIL reset_outputs: got %h required 0", outs); n_fail++;
    end
    n_checks++;
    if (wb_data !== 32'h0) begin
      $display("FAIL reset_wb_data: got %h required 0", wb_data); n_fail++;
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    issue(1'b0, 1'b0, 32'h0000_00A5, 32'h0, 5'd3);
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 32'h0000_00A5}) begin
      $display("FAIL pass_wb: got v=%b rd=%0d d=%h required v=1 rd=3 d=a5",
               wb_valid, wb_rd, wb_data); n_fail++;
    end
    n_checks++;
    if ({stall, mem_req} !== 2'b00) begin
      $display("FAIL pass_stall: got stall=%b req=%b required 0 0", stall, mem_req); n_fail++;
    end
    tick();
    n_checks++;
    if (wb_valid !== 1'b0) begin
      $display("FAIL pass_pulse: got wb_valid=%b required 0", wb_valid); n_fail++;
    end
  endtask

  task automatic test_load();
    int stalls = 0;
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd7);
    n_checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0010}) begin
      $display("FAIL load_req: got req=%b we=%b addr=%h required 1 0 00000010",
               mem_req, mem_we, mem_addr); n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      if (stall === 1'b1) stalls++;
      mem_ack   = (i == 2);
      mem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      tick();
    end
    idle_inputs();
    n_checks++;
    if (stalls != 3) begin
      $display("FAIL load_stall_cycles: got %0d required 3", stalls); n_fail++;
    end
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
      $display("FAIL load_wb: got v=%b rd=%0d d=%h required v=1 rd=7 d=deadbeef",
               wb_valid, wb_rd, wb_data); n_fail++;
    end
    n_checks++;
    if ({stall, mem_req} !== 2'b00) begin
      $display("FAIL load_done_idle: got stall=%b req=%b required 0 0", stall, mem_req);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_store();
    logic stable = 1'b1;
    logic wbseen = 1'b0;
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234, 5'd5);
    for (int i = 0; i < 3; i++) begin
      // Scribble on execute inputs; the request must not follow them.
      ex_result = 32'hFFFF_FFF0;
      ex_wdata  = 32'hCAFE_F00D;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'h1234}) stable = 1'b0;
      if (wb_valid !== 1'b0) wbseen = 1'b1;
      mem_ack = (i == 2);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (stable !== 1'b1) begin
      $display("FAIL store_hold: got unstable request required stable we=1 a=20 d=1234");
      n_fail++;
    end
    n_checks++;
    if ({wb_valid, wbseen, mem_req, stall} !== 4'b0000) begin
      $display("FAIL store_no_wb: got wb=%b seen=%b req=%b stall=%b required 0 0 0 0",
               wb_valid, wbseen, mem_req, stall); n_fail++;
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd9);
    n_checks++;
    if ({misalign, mem_req, wb_valid, stall} !== 4'b1000) begin
      $display("FAIL misalign_pulse: got mis=%b req=%b wb=%b stall=%b required 1 0 0 0",
               misalign, mem_req, wb_valid, stall); n_fail++;
    end
    tick();
    n_checks++;
    if ({misalign, mem_req} !== 2'b00) begin
      $display("FAIL misalign_clear: got mis=%b req=%b required 0 0", misalign, mem_req);
      n_fail++;
    end
  endtask

  task automatic test_load_priority();
    issue(1'b1, 1'b1, 32'h0000_0030, 32'h7777_7777, 5'd12);
    n_checks++;
    if ({mem_req, mem_we} !== 2'b10) begin
      $display("FAIL prio_we: got req=%b we=%b required 1 0", mem_req, mem_we); n_fail++;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    tick();
    idle_inputs();
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd12, 32'h55}) begin
      $display("FAIL prio_wb: got v=%b rd=%0d d=%h required 1 12 55",
               wb_valid, wb_rd, wb_data); n_fail++;
    end
    tick();
  endtask

  task automatic test_rd_zero_and_idle_ack();
    issue(1'b0, 1'b0, 32'h1111_2222, 32'h0, 5'd0);
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd0, 32'h1111_2222}) begin
      $display("FAIL rd0_wb: got v=%b rd=%0d d=%h required 1 0 11112222",
               wb_valid, wb_rd, wb_data); n_fail++;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h9999_9999;
    tick();
    tick();
    idle_inputs();
    n_checks++;
    if ({wb_valid, stall, mem_req} !== 3'b000) begin
      $display("FAIL idle_ack: got wb=%b stall=%b req=%b required 0 0 0",
               wb_valid, stall, mem_req); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd4);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA0A0_A0A0;
    tick();
    idle_inputs();
    n_checks++;
    if ({wb_valid, wb_data, stall} !== {1'b1, 32'hA0A0_A0A0, 1'b0}) begin
      $display("FAIL b2b_min_latency: got v=%b d=%h stall=%b required 1 a0a0a0a0 0",
               wb_valid, wb_data, stall); n_fail++;
    end
    issue(1'b0, 1'b0, 32'h0000_BEEF, 32'h0, 5'd6);
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd6, 32'h0000_BEEF}) begin
      $display("FAIL b2b_second: got v=%b rd=%0d d=%h required 1 6 0000beef",
               wb_valid, wb_rd, wb_data); n_fail++;
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    issue(1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd8);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, stall} !== 2'b00) begin
      $display("FAIL rst_mid_req: got req=%b stall=%b required 0 0", mem_req, stall); n_fail++;
    end
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    tick();
    idle_inputs();
    n_checks++;
    if ({wb_valid, mem_req, stall} !== 3'b000) begin
      $display("FAIL rst_late_ack: got wb=%b req=%b stall=%b required 0 0 0",
               wb_valid, mem_req, stall); n_fail++;
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int stalls = 0;
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd2);
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      tick();
    end
    n_checks++;
    if (stalls != 15) begin
      $display("FAIL timeout_cycles: got %0d required 15", stalls); n_fail++;
    end
    n_checks++;
    if ({bus_err, wb_valid, stall, mem_req} !== 4'b1000) begin
      $display("FAIL timeout_pulse: got err=%b wb=%b stall=%b req=%b required 1 0 0 0",
               bus_err, wb_valid, stall, mem_req); n_fail++;
    end
    tick();
    n_checks++;
    if (bus_err !== 1'b0) begin
      $display("FAIL timeout_clear: got bus_err=%b required 0", bus_err); n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_misalign();
    test_load_priority();
    test_rd_zero_and_idle_ack();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
